// File: rtl/memsys_pkg.sv
// Types shared across the memory system: main-memory FSM states, beat width and request record.
package memsys_pkg;

  localparam int unsigned DmaDataWidth = 4;
  localparam int unsigned BeatWidth    = DmaDataWidth * 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_e;

  typedef struct packed {
    logic                 we;
    logic [31:0]          addr;
    logic [BeatWidth-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Single-port line-wide backing store with a registered read port so it maps onto block RAM.
module mem_array #(
  parameter int unsigned width_p     = 128,
  parameter int unsigned lines_p     = 1024
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(lines_p)-1:0] idx_i,
  input  logic [width_p-1:0]         wdata_i,
  output logic [width_p-1:0]         rdata_o
);

  logic [width_p-1:0] mem_q [lines_p];
  logic [width_p-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
    rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_mem.sv
// Main-memory controller: one line-wide request at a time, fixed read/write latency,
// single-cycle read response pulse, writes complete silently.
module main_mem
  import memsys_pkg::*;
#(
  parameter int unsigned dma_data_width_p = DmaDataWidth,
  parameter int unsigned mem_lines_p      = 1024,
  parameter int unsigned rd_latency_p     = 4,
  parameter int unsigned wr_latency_p     = 2
) (
  input  logic                          clk_i,
  input  logic                          nreset_i,
  input  logic                          mem_valid_i,
  output logic                          mem_ready_o,
  input  logic                          mem_we_i,
  input  logic [31:0]                   mem_addr_i,
  input  logic [dma_data_width_p*32-1:0] mem_wdata_i,
  output logic                          mem_valid_o,
  output logic [dma_data_width_p*32-1:0] mem_data_o
);

  localparam int unsigned BeatW  = dma_data_width_p * 32;
  localparam int unsigned OffW   = $clog2(dma_data_width_p) + 2;
  localparam int unsigned IdxW   = $clog2(mem_lines_p);
  localparam int unsigned MaxLat = (rd_latency_p > wr_latency_p) ? rd_latency_p : wr_latency_p;
  localparam int unsigned CntW   = $clog2(MaxLat) + 1;
  localparam logic [CntW-1:0] RdCnt = CntW'(rd_latency_p - 1);
  localparam logic [CntW-1:0] WrCnt = CntW'(wr_latency_p - 1);

  mem_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  mem_req_t              req_q, req_d;
  logic [BeatW-1:0]      rd_hold_q, rd_hold_d;
  logic [IdxW-1:0]       arr_idx;
  logic                  arr_we;
  logic [BeatW-1:0]      arr_rdata;
  logic                  unused_addr;

  // While idle the array is addressed by the incoming request, so the registered
  // read is already valid by DONE even at latency 1.
  assign arr_idx = (state_q == IDLE) ? mem_addr_i[OffW +: IdxW] : req_q.addr[OffW +: IdxW];
  assign arr_we  = (state_q == DONE) && req_q.we;

  // Offset and upper address bits are deliberately ignored: beats align and the space wraps.
  assign unused_addr = ^req_q.addr;

  mem_array #(
    .width_p (BeatW),
    .lines_p (mem_lines_p)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .idx_i   (arr_idx),
    .wdata_i (req_q.wdata),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rd_hold_d   = rd_hold_q;
    mem_ready_o = 1'b0;
    mem_valid_o = 1'b0;
    mem_data_o  = rd_hold_q;
    unique case (state_q)
      IDLE: begin
        mem_ready_o = 1'b1;
        if (mem_valid_i) begin
          req_d   = '{we: mem_we_i, addr: mem_addr_i, wdata: mem_wdata_i};
          cnt_d   = mem_we_i ? WrCnt : RdCnt;
          state_d = ((mem_we_i ? WrCnt : RdCnt) == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = DONE;
      end
      DONE: begin
        if (!req_q.we) begin
          mem_valid_o = 1'b1;
          mem_data_o  = arr_rdata;
          rd_hold_d   = arr_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      rd_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      rd_hold_q <= rd_hold_d;
    end
  end

endmodule
